// File: rtl/axis_deadlock_stall_monitor.sv
// -----------------------------------------------------------------------------
// axis_deadlock_stall_monitor
//
// Watches the AXIS handshake block flags and the idle/block flags of the
// sub-instances of an HLS kernel. It declares a deadlock once the kernel has
// looked stalled for THRESH consecutive clock edges. A stalled kernel is one
// where something is blocked and every instance is either idle or stuck. The
// deadlock flag is sticky. It is released only by a clear pulse or by reset.
//
// State table:
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ST_MON     | armed, no stall seen on the last edge
//   ST_SUSPECT | stall seen on ctr_q consecutive edges, not yet THRESH
//   ST_LOCKED  | deadlock declared, outputs frozen until clear or reset
//
// Ports:
//   kernel_monitor_clock  in   kernel clock, all state on the rising edge
//   kernel_monitor_reset  in   asynchronous active-low reset
//   enable                in   1 = monitor armed (0 forces stall low)
//   clear                 in   1-cycle pulse: drop sticky state and re-arm
//   axis_mask             in   per-channel include mask
//   axis_block_sigs       in   per-channel TDATA handshake blocked flags
//   inst_idle_sigs        in   per-instance idle flags
//   inst_block_sigs       in   per-instance blocked (non-AXIS reason) flags
//   block                 out  sticky deadlock flag
//   block_pulse           out  one-cycle pulse when block rises
//   first_ch              out  lowest masked blocked channel on SUSPECT entry
//   blocked_snapshot      out  masked block flags captured at declaration
//   deadlock_count        out  saturating count of declared deadlocks
// -----------------------------------------------------------------------------
module axis_deadlock_stall_monitor #(
  parameter int unsigned              N_AXIS   = 14,
  parameter int unsigned              N_INST   = 3,
  parameter int unsigned              IDX_W    = 4,
  parameter logic [N_AXIS*IDX_W-1:0]  CH_OWNER = '0,
  parameter int unsigned              THRESH   = 16,
  parameter int unsigned              CNT_W    = 8
) (
  input  logic                kernel_monitor_clock,
  input  logic                kernel_monitor_reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [N_AXIS-1:0]   axis_mask,
  input  logic [N_AXIS-1:0]   axis_block_sigs,
  input  logic [N_INST-1:0]   inst_idle_sigs,
  input  logic [N_INST-1:0]   inst_block_sigs,
  output logic                block,
  output logic                block_pulse,
  output logic [IDX_W-1:0]    first_ch,
  output logic [N_AXIS-1:0]   blocked_snapshot,
  output logic [CNT_W-1:0]    deadlock_count
);

  // The counter only ever holds 1..THRESH-1. That range always fits in
  // clog2(THRESH) bits, so the counter can never wrap.
  localparam int unsigned      CTR_W    = $clog2(THRESH);
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_MON     = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t              state_q;
  logic [CTR_W-1:0]    ctr_q;
  logic [CTR_W-1:0]    ctr_d;
  logic                block_q;
  logic                block_pulse_q;
  logic [IDX_W-1:0]    first_ch_q;
  logic [N_AXIS-1:0]   snapshot_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;

  logic [N_AXIS-1:0]   blk_m;
  logic [N_INST-1:0]   inst_stuck;
  logic [IDX_W-1:0]    low_idx;
  logic                stall;

  // ---------------------------------------------------------------------------
  // Stall detection
  // ---------------------------------------------------------------------------
  always_comb begin
    blk_m = axis_block_sigs & axis_mask;

    // An instance counts as stuck when it reports a block itself. It also
    // counts as stuck when any masked channel it owns is blocked. Owner
    // codes that do not match any instance are simply ignored.
    inst_stuck = inst_block_sigs;
    for (int c = 0; c < int'(N_AXIS); c++) begin
      for (int i = 0; i < int'(N_INST); i++) begin
        if (blk_m[c] && (CH_OWNER[c*IDX_W +: IDX_W] == IDX_W'(i))) begin
          inst_stuck[i] = 1'b1;
        end
      end
    end

    // Scanning downwards leaves the lowest set index as the final value.
    low_idx = '0;
    for (int c = int'(N_AXIS) - 1; c >= 0; c--) begin
      if (blk_m[c]) begin
        low_idx = IDX_W'(c);
      end
    end

    stall = enable
          & ((|blk_m) | (|inst_block_sigs))
          & (&(inst_idle_sigs | inst_stuck));
  end

  // ---------------------------------------------------------------------------
  // Next-value helpers
  // ---------------------------------------------------------------------------
  always_comb begin
    ctr_d   = ctr_q + CTR_ONE;
    count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
    if (!kernel_monitor_reset) begin
      state_q       <= ST_MON;
      ctr_q         <= '0;
      block_q       <= 1'b0;
      block_pulse_q <= 1'b0;
      first_ch_q    <= '0;
      snapshot_q    <= '0;
      count_q       <= '0;
    end else begin
      block_pulse_q <= 1'b0;
      if (clear) begin
        // Clear beats any concurrent stall, so counting restarts on the next edge.
        // The event count deliberately survives a clear.
        state_q    <= ST_MON;
        ctr_q      <= '0;
        block_q    <= 1'b0;
        first_ch_q <= '0;
        snapshot_q <= '0;
      end else begin
        unique case (state_q)
          ST_MON: begin
            if (stall) begin
              state_q    <= ST_SUSPECT;
              ctr_q      <= CTR_ONE;
              first_ch_q <= low_idx;
            end
          end
          ST_SUSPECT: begin
            if (!stall) begin
              // first_ch is kept as a hint to the last suspect channel.
              state_q <= ST_MON;
              ctr_q   <= '0;
            end else if (ctr_q == CTR_LAST) begin
              state_q       <= ST_LOCKED;
              block_q       <= 1'b1;
              block_pulse_q <= 1'b1;
              snapshot_q    <= blk_m;
              count_q       <= count_d;
            end else begin
              ctr_q <= ctr_d;
            end
          end
          ST_LOCKED: begin
            // Frozen. Only clear or reset can leave this state.
          end
          default: begin
            state_q <= ST_MON;
            ctr_q   <= '0;
          end
        endcase
      end
    end
  end

  assign block            = block_q;
  assign block_pulse      = block_pulse_q;
  assign first_ch         = first_ch_q;
  assign blocked_snapshot = snapshot_q;
  assign deadlock_count   = count_q;

endmodule

// File: tb/tb_axis_deadlock_stall_monitor.sv
`timescale 1ns/1ps
module tb_axis_deadlock_stall_monitor;

  localparam int N_AXIS = 14;
  localparam int N_INST = 3;
  localparam int IDX_W  = 4;
  localparam int THRESH = 16;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Channel c is owned by instance c % N_INST.
  function automatic logic [N_AXIS*IDX_W-1:0] mk_owner();
    logic [N_AXIS*IDX_W-1:0] r;
    r = '0;
    for (int c = 0; c < N_AXIS; c++) r[c*IDX_W +: IDX_W] = IDX_W'(c % N_INST);
    return r;
  endfunction
  localparam logic [N_AXIS*IDX_W-1:0] OWNER = mk_owner();

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b1;
  logic               clear = 1'b0;
  logic [N_AXIS-1:0]  mask = '1;
  logic [N_AXIS-1:0]  ablk = '0;
  logic [N_INST-1:0]  iidle = '1;
  logic [N_INST-1:0]  iblk = '0;
  logic               block;
  logic               block_pulse;
  logic [IDX_W-1:0]   first_ch;
  logic [N_AXIS-1:0]  snapshot;
  logic [CNT_W-1:0]   deadlock_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axis_deadlock_stall_monitor #(
    .N_AXIS(N_AXIS), .N_INST(N_INST), .IDX_W(IDX_W),
    .CH_OWNER(OWNER), .THRESH(THRESH), .CNT_W(CNT_W)
  ) dut (
    .kernel_monitor_clock (clk),
    .kernel_monitor_reset (rst_n),
    .enable               (enable),
    .clear                (clear),
    .axis_mask            (mask),
    .axis_block_sigs      (ablk),
    .inst_idle_sigs       (iidle),
    .inst_block_sigs      (iblk),
    .block                (block),
    .block_pulse          (block_pulse),
    .first_ch             (first_ch),
    .blocked_snapshot     (snapshot),
    .deadlock_count       (deadlock_count)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: length of the current run of stalled edges.
  // ---------------------------------------------------------------------------
  int                m_run = 0;
  bit                m_locked = 0;
  bit                m_pulse = 0;
  int                m_first = 0;
  logic [N_AXIS-1:0] m_snap = '0;
  int                m_cnt = 0;

  function automatic bit m_stall();
    bit any_blk;
    bit all_ok;
    any_blk = 0;
    all_ok  = 1;
    for (int c = 0; c < N_AXIS; c++) if (ablk[c] && mask[c]) any_blk = 1;
    for (int i = 0; i < N_INST; i++) begin
      bit stuck;
      stuck = iblk[i];
      if (iblk[i]) any_blk = 1;
      for (int c = 0; c < N_AXIS; c++)
        if (ablk[c] && mask[c] && (c % N_INST) == i) stuck = 1;
      if (!(iidle[i] || stuck)) all_ok = 0;
    end
    return enable && any_blk && all_ok;
  endfunction

  function automatic int m_lowest();
    for (int c = 0; c < N_AXIS; c++) if (ablk[c] && mask[c]) return c;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_locked = 0; m_pulse = 0; m_first = 0; m_snap = '0; m_cnt = 0;
    end else begin
      m_pulse = 0;
      if (clear) begin
        m_run = 0; m_locked = 0; m_first = 0; m_snap = '0;
      end else if (!m_locked) begin
        if (m_stall()) begin
          m_run++;
          if (m_run == 1) m_first = m_lowest();
          if (m_run == THRESH) begin
            m_locked = 1;
            m_pulse  = 1;
            m_snap   = ablk & mask;
            if (m_cnt < CNT_MAX) m_cnt++;
          end
        end else begin
          m_run = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_block",    64'(block),          64'(m_locked));
    chk("m_pulse",    64'(block_pulse),    64'(m_pulse));
    chk("m_first_ch", 64'(first_ch),       64'(m_first));
    chk("m_snapshot", 64'(snapshot),       64'(m_snap));
    chk("m_count",    64'(deadlock_count), 64'(m_cnt));
  end

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change 1 ns after a falling edge.
  // ---------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #6;
  endtask

  task automatic defaults();
    enable = 1'b1; clear = 1'b0; mask = '1; ablk = '0; iidle = '1; iblk = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    defaults();
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_block", 64'(block), 64'd0);
    chk("rst_count", 64'(deadlock_count), 64'd0);

    // 1: single channel blocked, all instances idle
    ablk = 14'h0004;
    cyc(15);
    chk("t1_block_e15", 64'(block), 64'd0);
    cyc(1);
    chk("t1_block_e16", 64'(block), 64'd1);
    chk("t1_pulse",     64'(block_pulse), 64'd1);
    chk("t1_first_ch",  64'(first_ch), 64'd2);
    chk("t1_snapshot",  64'(snapshot), 64'h0004);
    chk("t1_count",     64'(deadlock_count), 64'd1);
    cyc(1);
    chk("t1_pulse_off", 64'(block_pulse), 64'd0);
    chk("t1_block_hold", 64'(block), 64'd1);

    // 2: one free cycle restarts the run
    do_reset();
    ablk = 14'h0004;
    cyc(15);
    ablk = '0;
    cyc(1);
    ablk = 14'h0004;
    cyc(15);
    chk("t2_block_e31", 64'(block), 64'd0);
    cyc(1);
    chk("t2_block_e32", 64'(block), 64'd1);
    chk("t2_count",     64'(deadlock_count), 64'd1);

    // 3: masked-off channel never stalls
    do_reset();
    mask = ~14'h0020;
    ablk = 14'h0020;
    cyc(100);
    chk("t3_block", 64'(block), 64'd0);
    chk("t3_count", 64'(deadlock_count), 64'd0);

    // 4: inst1 busy; ch0 (owned by inst0) blocked -> no stall until inst1 blocks
    do_reset();
    iidle = 3'b100;
    ablk  = 14'h0001;
    cyc(40);
    chk("t4_no_lock", 64'(block), 64'd0);
    iblk = 3'b010;
    cyc(15);
    chk("t4_block_e15", 64'(block), 64'd0);
    cyc(1);
    chk("t4_block_e16", 64'(block), 64'd1);
    chk("t4_snapshot",  64'(snapshot), 64'h0001);

    // 4b: ch1 belongs to inst1, so blocking ch0 and ch1 makes both stuck
    do_reset();
    iidle = 3'b100;
    ablk  = 14'h0003;
    cyc(16);
    chk("t4b_block",    64'(block), 64'd1);
    chk("t4b_first_ch", 64'(first_ch), 64'd0);
    chk("t4b_snapshot", 64'(snapshot), 64'h0003);

    // 5: clear while locked with the stall still present
    do_reset();
    ablk = 14'h0004;
    cyc(16);
    chk("t5_block_pre", 64'(block), 64'd1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("t5_block_clr", 64'(block), 64'd0);
    chk("t5_snap_clr",  64'(snapshot), 64'h0000);
    chk("t5_cnt_kept",  64'(deadlock_count), 64'd1);
    cyc(15);
    chk("t5_block_e15", 64'(block), 64'd0);
    cyc(1);
    chk("t5_block_e16", 64'(block), 64'd1);
    chk("t5_count",     64'(deadlock_count), 64'd2);

    // 7: enable low mid-suspect resets the run; enable low while locked is ignored
    do_reset();
    ablk = 14'h0400;
    cyc(10);
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    cyc(15);
    chk("t7_block_e15", 64'(block), 64'd0);
    cyc(1);
    chk("t7_block_e16", 64'(block), 64'd1);
    chk("t7_first_ch",  64'(first_ch), 64'd10);
    enable = 1'b0;
    cyc(5);
    chk("t7_locked_hold", 64'(block), 64'd1);
    enable = 1'b1;

    // 6: async reset mid-suspect, then saturate the event counter
    do_reset();
    ablk = 14'h0008;
    cyc(10);
    chk("t6_first_pre", 64'(first_ch), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_first", 64'(first_ch), 64'd0);
    chk("t6_async_block", 64'(block), 64'd0);
    chk("t6_async_count", 64'(deadlock_count), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= CNT_MAX + 5; k++) begin
      cyc(16);
      if (k == 1)       chk("t6_cnt_1",   64'(deadlock_count), 64'd1);
      if (k == CNT_MAX) chk("t6_cnt_255", 64'(deadlock_count), 64'd255);
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
    end
    chk("t6_cnt_sat", 64'(deadlock_count), 64'd255);
    cyc(16);
    chk("t6_block_after_sat", 64'(block), 64'd1);
    chk("t6_cnt_sat2",        64'(deadlock_count), 64'd255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
